// File: rtl/forward_stall_ctrl.sv
// forward_stall_ctrl
//
// Purpose:
//   Forwarding and load-use hazard controller for the EX stage of a 5-stage
//   pipeline. It shadows the destination information of the instructions in
//   ID/EX (S1) and EX/MEM (S2). From those it drives the EX operand mux
//   selects and flags load-use stalls.
//   Select encoding: 00 = register file, 01 = EX/MEM result, 10 = MEM/WB result.
//
// Ports:
//   Clk        in   1       pipeline clock, rising edge
//   Reset      in   1       asynchronous, active-high
//   IdValid    in   1       ID stage holds a real instruction
//   IdRs/IdRt  in   ADDR_W  source registers of the ID instruction
//   IdUsesRs/IdUsesRt in 1  ID instruction reads Rs / Rt
//   IdDst      in   ADDR_W  destination register of the ID instruction
//   IdRegWrite in   1       ID instruction writes the register file
//   IdMemRead  in   1       ID instruction is a load
//   Flush      in   1       squash of the ID instruction
//   Stall      out  1       hold PC and IF/ID, bubble ID/EX (combinational)
//   ForwardA/B out  2       EX operand mux selects (registered)
//
// Optional build macro HAZARD_STATS_EN adds:
//   StallCount out  CNT_W   saturating count of stalled edges
//   FwdCount   out  CNT_W   saturating count of advances that forward an operand
module forward_stall_ctrl #(
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              IdValid,
  input  logic [ADDR_W-1:0] IdRs,
  input  logic [ADDR_W-1:0] IdRt,
  input  logic              IdUsesRs,
  input  logic              IdUsesRt,
  input  logic [ADDR_W-1:0] IdDst,
  input  logic              IdRegWrite,
  input  logic              IdMemRead,
  input  logic              Flush,
  output logic              Stall,
  output logic [1:0]        ForwardA,
  output logic [1:0]        ForwardB
`ifdef HAZARD_STATS_EN
  ,
  output logic [CNT_W-1:0]  StallCount,
  output logic [CNT_W-1:0]  FwdCount
`endif
);

  // S1 = ID/EX shadow, S2 = EX/MEM shadow. S2 does not keep the load flag:
  // a load that has reached EX/MEM never causes a stall.
  logic              s1_valid, s1_regwrite, s1_memread;
  logic [ADDR_W-1:0] s1_dst;
  logic              s2_valid, s2_regwrite;
  logic [ADDR_W-1:0] s2_dst;

  logic              adv;
  logic [1:0]        fwd_a_next, fwd_b_next;

  // Register 0 is hard-wired zero, so it is never a forwarding source.
  function automatic logic hit(input logic valid, input logic regwrite,
                               input logic [ADDR_W-1:0] dst,
                               input logic [ADDR_W-1:0] r);
    return valid & regwrite & (dst != '0) & (dst == r);
  endfunction

  // Newest producer wins: EX/MEM (S1) before MEM/WB (S2).
  function automatic logic [1:0] sel(input logic uses, input logic [ADDR_W-1:0] r,
                                     input logic hit1, input logic hit2);
    if (!uses)     return 2'b00;
    else if (hit1) return 2'b01;
    else if (hit2) return 2'b10;
    else           return 2'b00;
  endfunction

  logic hit1_rs, hit1_rt, hit2_rs, hit2_rt;

  always_comb begin
    hit1_rs = hit(s1_valid, s1_regwrite, s1_dst, IdRs);
    hit1_rt = hit(s1_valid, s1_regwrite, s1_dst, IdRt);
    hit2_rs = hit(s2_valid, s2_regwrite, s2_dst, IdRs);
    hit2_rt = hit(s2_valid, s2_regwrite, s2_dst, IdRt);
  end

  // Only a load still in ID/EX can stall; its data is not ready until MEM/WB.
  // Flush forces Stall low so the squashed instruction simply becomes a bubble.
  assign Stall = IdValid & ~Flush & s1_memread &
                 ((IdUsesRs & hit1_rs) | (IdUsesRt & hit1_rt));

  assign adv = IdValid & ~Stall & ~Flush;

  always_comb begin
    fwd_a_next = 2'b00;
    fwd_b_next = 2'b00;
    if (adv) begin
      fwd_a_next = sel(IdUsesRs, IdRs, hit1_rs, hit2_rs);
      fwd_b_next = sel(IdUsesRt, IdRt, hit1_rt, hit2_rt);
    end
  end

  // ID -> EX boundary: shadow pipe advance and select registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid    <= 1'b0;
      s1_dst      <= '0;
      s1_regwrite <= 1'b0;
      s1_memread  <= 1'b0;
      s2_valid    <= 1'b0;
      s2_dst      <= '0;
      s2_regwrite <= 1'b0;
      ForwardA    <= 2'b00;
      ForwardB    <= 2'b00;
    end else begin
      s2_valid    <= s1_valid;
      s2_dst      <= s1_dst;
      s2_regwrite <= s1_regwrite;
      if (adv) begin
        s1_valid    <= 1'b1;
        s1_dst      <= IdDst;
        s1_regwrite <= IdRegWrite;
        s1_memread  <= IdMemRead;
      end else begin
        s1_valid    <= 1'b0;
        s1_dst      <= '0;
        s1_regwrite <= 1'b0;
        s1_memread  <= 1'b0;
      end
      ForwardA <= fwd_a_next;
      ForwardB <= fwd_b_next;
    end
  end

`ifdef HAZARD_STATS_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
    return (&c) ? c : c + 1'b1;
  endfunction

  logic fwd_event;
  assign fwd_event = adv & ((fwd_a_next != 2'b00) | (fwd_b_next != 2'b00));

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      StallCount <= '0;
      FwdCount   <= '0;
    end else begin
      if (Stall)     StallCount <= sat_inc(StallCount);
      if (fwd_event) FwdCount   <= sat_inc(FwdCount);
    end
  end
`endif

endmodule

// File: tb/tb_forward_stall_ctrl.sv
// Scoreboard bench for forward_stall_ctrl: directed hazard scenarios followed
// by randomized instruction streams, compared against a reference model that
// keeps the list of instructions currently in EX and MEM.
module tb_forward_stall_ctrl;

  logic       Clk, Reset;
  logic       IdValid, IdUsesRs, IdUsesRt, IdRegWrite, IdMemRead, Flush;
  logic [4:0] IdRs, IdRt, IdDst;
  logic       Stall;
  logic [1:0] ForwardA, ForwardB;
`ifdef HAZARD_STATS_EN
  logic [15:0] StallCount, FwdCount;
`endif

  forward_stall_ctrl #(.ADDR_W(5), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .IdValid(IdValid), .IdRs(IdRs), .IdRt(IdRt),
    .IdUsesRs(IdUsesRs), .IdUsesRt(IdUsesRt), .IdDst(IdDst),
    .IdRegWrite(IdRegWrite), .IdMemRead(IdMemRead), .Flush(Flush),
    .Stall(Stall), .ForwardA(ForwardA), .ForwardB(ForwardB)
`ifdef HAZARD_STATS_EN
    , .StallCount(StallCount), .FwdCount(FwdCount)
`endif
  );

  initial Clk = 1'b0;
  always #10 Clk = ~Clk;

  int vectors = 0;
  int miscompares = 0;

  typedef struct packed {
    logic       v;
    logic       rw;
    logic       mr;
    logic [4:0] dst;
  } ins_t;

  typedef struct packed {
    logic       stall;
    logic [1:0] fa;
    logic [1:0] fb;
  } exp_t;

  // Model state: hist[0] is the instruction in EX, hist[1] the one in MEM.
  ins_t hist[$];
  logic [1:0] m_fa, m_fb;
  logic       m_stall;
  int         m_stall_cnt, m_fwd_cnt;
  exp_t       exp_q[$];

  task automatic check(input string name, input int got, input int want);
    vectors++;
    if (got != want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  function automatic int producer(input logic [4:0] r);
    for (int i = 0; i < 2; i++)
      if (hist[i].v && hist[i].rw && hist[i].dst != 5'd0 && hist[i].dst == r)
        return i;
    return -1;
  endfunction

  function automatic logic [1:0] sel_of(input logic uses, input logic [4:0] r);
    int p;
    p = producer(r);
    if (!uses)  return 2'b00;
    if (p == 0) return 2'b01;
    if (p == 1) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear();
    hist.delete();
    hist.push_back('0);
    hist.push_back('0);
    m_fa = 2'b00;
    m_fb = 2'b00;
    m_stall = 1'b0;
    m_stall_cnt = 0;
    m_fwd_cnt = 0;
  endtask

  // Drive one ID-stage instruction for one cycle and record what the DUT must show.
  task automatic step(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] dst,
                      input logic rw, input logic mr, input logic fl);
    exp_t e;
    logic adv;
    ins_t ni;
    @(negedge Clk);
    #1;
    IdValid = v; IdRs = rs; IdRt = rt; IdUsesRs = urs; IdUsesRt = urt;
    IdDst = dst; IdRegWrite = rw; IdMemRead = mr; Flush = fl;
    m_stall = v && !fl && hist[0].mr &&
              ((urs && producer(rs) == 0) || (urt && producer(rt) == 0));
    e.stall = m_stall;
    e.fa = m_fa;
    e.fb = m_fb;
    exp_q.push_back(e);
    adv = v && !m_stall && !fl;
    m_fa = adv ? sel_of(urs, rs) : 2'b00;
    m_fb = adv ? sel_of(urt, rt) : 2'b00;
    if (m_stall) m_stall_cnt++;
    if (adv && (m_fa != 2'b00 || m_fb != 2'b00)) m_fwd_cnt++;
    ni.v = adv; ni.rw = adv ? rw : 1'b0; ni.mr = adv ? mr : 1'b0; ni.dst = adv ? dst : 5'd0;
    hist.push_front(ni);
    void'(hist.pop_back());
  endtask

  task automatic nop();
    step(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0);
  endtask

  // Reset mid-cycle: outputs must clear without waiting for a clock edge.
  task automatic mid_reset();
    #4;
    Reset = 1'b1;
    IdValid = 1'b0;
    Flush = 1'b0;
    #1;
    check("reset_stall", Stall, 0);
    check("reset_fwda", ForwardA, 0);
    check("reset_fwdb", ForwardB, 0);
    model_clear();
    @(negedge Clk);
    Reset = 1'b0;
  endtask

  // Monitor: compares each recorded expectation once the cycle has settled.
  initial begin
    exp_t e;
    forever begin
      @(negedge Clk);
      #3;
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        check("stall", Stall, e.stall);
        check("fwda", ForwardA, e.fa);
        check("fwdb", ForwardB, e.fb);
      end
    end
  end

  initial begin
    logic       v, urs, urt, rw, mr, fl;
    logic [4:0] rs, rt, dst;
    Reset = 1'b1;
    IdValid = 0; IdRs = 0; IdRt = 0; IdUsesRs = 0; IdUsesRt = 0;
    IdDst = 0; IdRegWrite = 0; IdMemRead = 0; Flush = 0;
    model_clear();
    @(negedge Clk);
    Reset = 1'b0;

    // add r8; sub reads r8 (Rs) -> ForwardA 01, ForwardB 00
    step(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 0);
    step(1, 5'd8, 5'd2, 1, 1, 5'd11, 1, 0, 0);
    // add r9; nop; or reads r9 (Rt) -> ForwardB 10
    step(1, 5'd1, 5'd2, 1, 1, 5'd9, 1, 0, 0);
    nop();
    step(1, 5'd3, 5'd9, 1, 1, 5'd12, 1, 0, 0);
    // lw r10; add reads r10 -> one stall then ForwardA 10
    step(1, 5'd4, 5'd0, 1, 0, 5'd10, 1, 1, 0);
    step(1, 5'd10, 5'd4, 1, 1, 5'd13, 1, 0, 0);
    step(1, 5'd10, 5'd4, 1, 1, 5'd13, 1, 0, 0);
    nop();
    // writes to r0 and loads into r0, readers of r0 -> 00, no stall
    step(1, 5'd1, 5'd1, 1, 1, 5'd0, 1, 0, 0);
    step(1, 5'd0, 5'd0, 1, 1, 5'd14, 1, 0, 0);
    step(1, 5'd1, 5'd0, 1, 0, 5'd0, 1, 1, 0);
    step(1, 5'd0, 5'd0, 1, 1, 5'd15, 1, 0, 0);
    // r5 produced twice: newest (S1) wins -> 01
    step(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    step(1, 5'd1, 5'd2, 1, 1, 5'd5, 1, 0, 0);
    step(1, 5'd5, 5'd5, 1, 1, 5'd16, 1, 0, 0);
    // operands hitting different stages in one cycle
    step(1, 5'd1, 5'd2, 1, 1, 5'd6, 1, 0, 0);
    step(1, 5'd1, 5'd2, 1, 1, 5'd7, 1, 0, 0);
    step(1, 5'd6, 5'd7, 1, 1, 5'd17, 1, 0, 0);
    // lw r3; dependent flushed -> no stall, bubble, then load forwards from S2
    step(1, 5'd4, 5'd0, 1, 0, 5'd3, 1, 1, 0);
    step(1, 5'd3, 5'd0, 1, 0, 5'd18, 1, 0, 1);
    step(1, 5'd3, 5'd3, 1, 1, 5'd19, 1, 0, 0);
    nop();
    // reset during a load-use stall; reader of r8 afterwards gets 00
    step(1, 5'd1, 5'd2, 1, 1, 5'd8, 1, 0, 0);
    step(1, 5'd4, 5'd0, 1, 0, 5'd10, 1, 1, 0);
    step(1, 5'd10, 5'd8, 1, 1, 5'd20, 1, 0, 0);
    mid_reset();
    step(1, 5'd8, 5'd8, 1, 1, 5'd21, 1, 0, 0);
    nop();

    // Randomized stream; a stalled instruction is re-presented until it advances.
    v = 0; rs = 0; rt = 0; urs = 0; urt = 0; dst = 0; rw = 0; mr = 0; fl = 0;
    for (int i = 0; i < 400; i++) begin
      if (!m_stall) begin
        v   = ($urandom_range(0, 9) != 0);
        rs  = 5'($urandom_range(0, 6));
        rt  = 5'($urandom_range(0, 6));
        urs = $urandom_range(0, 3) != 0;
        urt = $urandom_range(0, 1) != 0;
        dst = 5'($urandom_range(0, 6));
        rw  = $urandom_range(0, 3) != 0;
        mr  = rw && ($urandom_range(0, 2) == 0);
      end
      fl = ($urandom_range(0, 9) == 0);
      step(v, rs, rt, urs, urt, dst, rw, mr, fl);
      if (i == 200) mid_reset();
    end
    nop();
    nop();

    @(negedge Clk);
    #5;
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
`ifdef HAZARD_STATS_EN
    check("stall_count", StallCount, m_stall_cnt);
    check("fwd_count", FwdCount, m_fwd_cnt);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
